// File: rtl/spi_arb_pkg.sv
// ----------------------------------------------------------------------------
// spi_arb_pkg
// Shared types and constants for the SPI round-robin scheduler.
//   state_t       : scheduler FSM state (IDLE, LAUNCH, WAIT, GAP)
//   ERR_WORD      : read word returned when the watchdog aborts a transaction
//   NREQ_DEF      : default number of requesters
//   TO_CYCLES_DEF : default watchdog limit (used with SPI_ARB_TIMEOUT_EN)
// ----------------------------------------------------------------------------
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      GAP    = 2'd3
   } state_t;

   localparam logic [15:0] ERR_WORD      = 16'hDEAD;
   localparam int          NREQ_DEF      = 4;
   localparam int          TO_CYCLES_DEF = 4096;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req_i starting at last_i+1 and
// wrapping modulo NREQ; the first set bit wins.
//   req_i    [NREQ-1:0] : request vector
//   last_i   [IW-1:0]   : index of the most recently served requester
//   any_o               : at least one request is set
//   winner_o [IW-1:0]   : index of the selected requester (0 when none)
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   last_i,
   output logic            any_o,
   output logic [IW-1:0]   winner_o
);

   // Walk the offsets from farthest to nearest so the nearest set bit
   // (smallest offset after last_i) is the last one written.
   always_comb begin
      winner_o = '0;
      any_o    = |req_i;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_i[(int'(last_i) + k) % NREQ]) begin
            winner_o = IW'((int'(last_i) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/spi_arb.sv
// ----------------------------------------------------------------------------
// spi_arb
// Round-robin scheduler sharing one 16-bit SPI master between NREQ
// requesters. One transaction at a time; the read word is returned to the
// requester that owns the transaction.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req     [NREQ-1:0] : level request per requester, held until its rsp_vld
//   req_cmd [16*NREQ-1:0] : command slice per requester
//   rsp_vld [NREQ-1:0] : one-hot completion pulse
//   rsp_data[15:0]     : read word, held until the next completion
//   busy               : high from launch until completion
//   err                : watchdog abort pulse (0 unless SPI_ARB_TIMEOUT_EN)
//   wrt, cmd[15:0]     : start pulse and command to the SPI master
//   done, rd_data[15:0]: SPI master status and shifted-in word
//
// Handshake: req[i] is a level held until rsp_vld[i]; rsp_vld is a single
// cycle pulse. Toward the master, wrt pulses for one cycle with cmd stable;
// done is ignored during LAUNCH because the master only clears it the cycle
// after wrt, and is sampled in WAIT.
//
// Optional: define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog of TO_CYCLES.
// ----------------------------------------------------------------------------
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [16*NREQ-1:0]   req_cmd,
   output logic [NREQ-1:0]      rsp_vld,
   output logic [15:0]          rsp_data,
   output logic                 busy,
   output logic                 err,
   output logic                 wrt,
   output logic [15:0]          cmd,
   input  logic                 done,
   input  logic [15:0]          rd_data
);

   localparam int IW = $clog2(NREQ);

   state_t            state_q, state_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [15:0]       cmd_q, cmd_d;
   logic              wrt_q, wrt_d;
   logic              busy_q, busy_d;
   logic [NREQ-1:0]   rsp_vld_q, rsp_vld_d;
   logic [15:0]       rsp_data_q, rsp_data_d;
   logic              any;
   logic [IW-1:0]     winner;
   logic              timeout;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req_i    (req),
      .last_i   (last_q),
      .any_o    (any),
      .winner_o (winner)
   );

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES);

   logic [CW-1:0] cnt_q;
   logic          err_q;

   // Counter is zero on entry to WAIT (it is cleared in every other state)
   // and advances once per WAIT cycle; done has priority over the abort.
   assign timeout = (state_q == WAIT) && !done && (cnt_q == CW'(TO_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
         err_q <= timeout;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= IW'(NREQ - 1);
         owner_q    <= '0;
         cmd_q      <= '0;
         wrt_q      <= 1'b0;
         busy_q     <= 1'b0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         cmd_q      <= cmd_d;
         wrt_q      <= wrt_d;
         busy_q     <= busy_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any) state_d = LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT:    if (done || timeout) state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      last_d     = last_q;
      owner_d    = owner_q;
      cmd_d      = cmd_q;
      wrt_d      = 1'b0;
      busy_d     = busy_q;
      rsp_vld_d  = '0;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               cmd_d   = req_cmd[{winner, 4'h0} +: 16];
               wrt_d   = 1'b1;
               owner_d = winner;
               busy_d  = 1'b1;
            end
         end
         WAIT: begin
            if (done || timeout) begin
               rsp_data_d = done ? rd_data : ERR_WORD;
               rsp_vld_d  = NREQ'(1) << owner_q;
               last_d     = owner_q;
               busy_d     = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = rsp_data_q;
   assign busy     = busy_q;
   assign wrt      = wrt_q;
   assign cmd      = cmd_q;

endmodule

// File: tb/tb_spi_arb.sv
// ----------------------------------------------------------------------------
// tb_spi_arb
// Directed bench for spi_arb (NREQ=4, TO_CYCLES=64). A small SPI slave model
// drops done the cycle after wrt, keeps it low for slv_lat further cycles,
// then raises it with slv_resp on rd_data. slv_hold freezes the slave.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_arb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] req_cmd;
   logic [3:0]  rsp_vld;
   logic [15:0] rsp_data;
   logic        busy;
   logic        err;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;

   int total = 0;
   int bad   = 0;

   logic [15:0] cmds [4] = '{16'hA5C3, 16'hB201, 16'hC302, 16'hD403};

   // slave model controls
   int          slv_lat  = 3;
   bit          slv_hold = 1'b0;
   logic [15:0] slv_resp = 16'h0000;
   int          slv_cnt;

   spi_arb #(.NREQ(4), .TO_CYCLES(64)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_cmd  (req_cmd),
      .rsp_vld  (rsp_vld),
      .rsp_data (rsp_data),
      .busy     (busy),
      .err      (err),
      .wrt      (wrt),
      .cmd      (cmd),
      .done     (done),
      .rd_data  (rd_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPI slave model (shares rst_n with the arbiter)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b1;
         rd_data <= 16'h0000;
         slv_cnt <= 0;
      end else if (wrt) begin
         done    <= 1'b0;
         slv_cnt <= slv_lat;
      end else if (!done && !slv_hold) begin
         if (slv_cnt == 0) begin
            done    <= 1'b1;
            rd_data <= slv_resp;
         end else begin
            slv_cnt <= slv_cnt - 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n    = 1'b0;
      req      = 4'b0000;
      req_cmd  = {cmds[3], cmds[2], cmds[1], cmds[0]};
      slv_lat  = 3;
      slv_hold = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Steps negedges until wrt is seen; cycles counts negedges waited.
   task automatic wait_wrt(input int budget, output int cycles,
                           output logic [15:0] wcmd, output bit to);
      to = 1'b1; cycles = 0; wcmd = '0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (wrt) begin
            cycles = c; wcmd = cmd; to = 1'b0;
            return;
         end
      end
   endtask

   // Steps negedges until a completion; counts wrt pulses seen on the way.
   task automatic run_until_rsp(input int budget, input bit drop,
                                output logic [3:0] vld, output logic [15:0] data,
                                output logic e, output int wrts,
                                output logic [15:0] wcmd, output int cycles,
                                output bit to);
      to = 1'b1; vld = '0; data = '0; e = 1'b0; wrts = 0; wcmd = '0; cycles = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (wrt) begin
            wrts++; wcmd = cmd;
         end
         if (rsp_vld != 4'b0000) begin
            vld = rsp_vld; data = rsp_data; e = err; cycles = c; to = 1'b0;
            if (drop) req = req & ~rsp_vld;
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      total++; if (wrt !== 1'b0) begin bad++; $display("FAIL reset_wrt got=%b exp=0", wrt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL reset_rsp_vld got=%b exp=0000", rsp_vld); end
      total++; if (rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
      total++; if (cmd !== 16'h0000) begin bad++; $display("FAIL reset_cmd got=%h exp=0000", cmd); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_single();
      int          wrts = 0;
      logic [15:0] wcmd = '0;
      logic [3:0]  vld = '0;
      logic [15:0] data = '0;
      logic        e = 1'b0;
      bit          in_txn = 1'b0;
      int          busy_bad = 0;
      bit          seen = 1'b0;
      do_reset();
      slv_resp = 16'h1234;
      req = 4'b0001;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (wrt) begin wrts++; wcmd = cmd; in_txn = 1'b1; end
         if (rsp_vld != 4'b0000 && !seen) begin
            vld = rsp_vld; data = rsp_data; e = err; in_txn = 1'b0; seen = 1'b1;
            req = 4'b0000;
         end
         if (busy !== in_txn) busy_bad++;
      end
      total++; if (wrts != 1) begin bad++; $display("FAIL single_wrt_count got=%0d exp=1", wrts); end
      total++; if (wcmd !== 16'hA5C3) begin bad++; $display("FAIL single_cmd got=%h exp=a5c3", wcmd); end
      total++; if (vld !== 4'b0001) begin bad++; $display("FAIL single_rsp_vld got=%b exp=0001", vld); end
      total++; if (data !== 16'h1234) begin bad++; $display("FAIL single_rsp_data got=%h exp=1234", data); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", e); end
      total++; if (busy_bad != 0) begin bad++; $display("FAIL single_busy_window got=%0d exp=0 bad cycles", busy_bad); end
      total++; if (rsp_data !== 16'h1234) begin bad++; $display("FAIL single_rsp_hold got=%h exp=1234", rsp_data); end
   endtask

   task automatic test_all_requesting();
      int          exp_order [5] = '{0, 1, 2, 3, 0};
      logic [3:0]  vld;
      logic [15:0] data, wcmd;
      logic        e;
      int          wrts, cyc;
      bit          to;
      do_reset();
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         slv_resp = 16'h5000 + 16'(t);
         run_until_rsp(50, 1'b1, vld, data, e, wrts, wcmd, cyc, to);
         total++;
         if (to) begin
            bad++; $display("FAIL all_timeout txn=%0d got=no rsp exp=rsp", t);
         end else begin
            if (vld !== (4'b0001 << exp_order[t]) || wcmd !== cmds[exp_order[t]] ||
                wrts != 1 || data !== 16'h5000 + 16'(t)) begin
               bad++;
               $display("FAIL all_grant txn=%0d got vld=%b cmd=%h wrts=%0d data=%h exp vld=%b cmd=%h wrts=1 data=%h",
                        t, vld, wcmd, wrts, data, 4'b0001 << exp_order[t], cmds[exp_order[t]],
                        16'h5000 + 16'(t));
            end
         end
         req = 4'b1111;
      end
      req = 4'b0000;
   endtask

   task automatic test_late_arrival();
      logic [3:0]  vld;
      logic [15:0] data, wcmd;
      logic        e;
      int          wrts, cyc;
      bit          to;
      do_reset();
      slv_lat = 6;
      slv_resp = 16'h0A0A;
      req = 4'b0001;
      wait_wrt(20, cyc, wcmd, to);
      @(negedge clk);
      req[2] = 1'b1;
      run_until_rsp(50, 1'b1, vld, data, e, wrts, wcmd, cyc, to);
      total++; if (to || wrts != 0 || vld !== 4'b0001) begin
         bad++; $display("FAIL late_first got vld=%b wrts=%0d to=%0d exp vld=0001 wrts=0 to=0", vld, wrts, to);
      end
      run_until_rsp(50, 1'b1, vld, data, e, wrts, wcmd, cyc, to);
      total++; if (to || wrts != 1 || vld !== 4'b0100 || wcmd !== cmds[2]) begin
         bad++; $display("FAIL late_second got vld=%b wrts=%0d cmd=%h exp vld=0100 wrts=1 cmd=%h", vld, wrts, wcmd, cmds[2]);
      end
      req = 4'b0000;
   endtask

   task automatic test_dropped_req();
      logic [3:0]  vld;
      logic [15:0] data, wcmd;
      logic        e;
      int          wrts, cyc;
      bit          to;
      do_reset();
      slv_resp = 16'h7777;
      req = 4'b0010;
      wait_wrt(20, cyc, wcmd, to);
      req = 4'b0000;
      run_until_rsp(50, 1'b0, vld, data, e, wrts, wcmd, cyc, to);
      total++; if (to || vld !== 4'b0010 || data !== 16'h7777) begin
         bad++; $display("FAIL dropped_rsp got vld=%b data=%h to=%0d exp vld=0010 data=7777 to=0", vld, data, to);
      end
      // rsp seen in GAP; GAP->IDLE, then IDLE grants: wrt visible 2 negedges on
      req = 4'b0001;
      wait_wrt(20, cyc, wcmd, to);
      total++; if (to || cyc != 2 || wcmd !== cmds[0]) begin
         bad++; $display("FAIL dropped_next got cycles=%0d cmd=%h exp cycles=2 cmd=%h", cyc, wcmd, cmds[0]);
      end
      req = 4'b0000;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          c1, c2;
      logic [15:0] wcmd;
      bit          to1, to2;
      do_reset();
      slv_lat = 3;
      req = 4'b1000;
      wait_wrt(20, c1, wcmd, to1);
      total++; if (to1 || wcmd !== cmds[3]) begin
         bad++; $display("FAIL b2b_first got cmd=%h to=%0d exp cmd=%h", wcmd, to1, cmds[3]);
      end
      // spacing = 1 (slave sees wrt) + slv_lat + 1 (done up) + 1 (WAIT) + 1 (GAP) + 1 (IDLE)
      wait_wrt(40, c2, wcmd, to2);
      total++; if (to2 || c2 != 8 || wcmd !== cmds[3]) begin
         bad++; $display("FAIL b2b_spacing got cycles=%0d cmd=%h exp cycles=8 cmd=%h", c2, wcmd, cmds[3]);
      end
      req = 4'b0000;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_async_reset();
      int          cyc;
      logic [15:0] wcmd;
      bit          to;
      do_reset();
      slv_lat = 10;
      req = 4'b0100;
      wait_wrt(20, cyc, wcmd, to);
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b1 || cmd !== cmds[2]) begin
         bad++; $display("FAIL areset_pre got busy=%b cmd=%h exp busy=1 cmd=%h", busy, cmd, cmds[2]);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || wrt !== 1'b0 || rsp_vld !== 4'b0000 || cmd !== 16'h0000 || rsp_data !== 16'h0000) begin
         bad++; $display("FAIL areset_outputs got busy=%b wrt=%b vld=%b cmd=%h data=%h exp all 0",
                         busy, wrt, rsp_vld, cmd, rsp_data);
      end
      @(negedge clk);
      req = 4'b0101;
      rst_n = 1'b1;
      wait_wrt(20, cyc, wcmd, to);
      total++; if (to || cyc != 1 || wcmd !== cmds[0]) begin
         bad++; $display("FAIL areset_next got cycles=%0d cmd=%h exp cycles=1 cmd=%h", cyc, wcmd, cmds[0]);
      end
      req = 4'b0000;
      repeat (30) @(negedge clk);
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic test_watchdog();
      logic [3:0]  vld;
      logic [15:0] data, wcmd;
      logic        e;
      int          wrts, cyc;
      bit          to;
      do_reset();
      slv_hold = 1'b1;
      slv_resp = 16'h4321;
      req = 4'b0011;
      wait_wrt(20, cyc, wcmd, to);
      // WAIT starts one edge after wrt; abort on its 64th cycle
      run_until_rsp(200, 1'b1, vld, data, e, wrts, wcmd, cyc, to);
      total++; if (to || cyc != 65 || vld !== 4'b0001 || e !== 1'b1 || data !== 16'hDEAD) begin
         bad++; $display("FAIL wdog_abort got cycles=%0d vld=%b err=%b data=%h exp cycles=65 vld=0001 err=1 data=dead",
                         cyc, vld, e, data);
      end
      slv_hold = 1'b0;
      run_until_rsp(50, 1'b1, vld, data, e, wrts, wcmd, cyc, to);
      total++; if (to || vld !== 4'b0010 || e !== 1'b0 || data !== 16'h4321 || wcmd !== cmds[1]) begin
         bad++; $display("FAIL wdog_next got vld=%b err=%b data=%h cmd=%h exp vld=0010 err=0 data=4321 cmd=%h",
                         vld, e, data, wcmd, cmds[1]);
      end
      req = 4'b0000;
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      req = 4'b0000;
      req_cmd = '0;
      test_reset();
      test_single();
      test_all_requesting();
      test_late_arrival();
      test_dropped_req();
      test_back_to_back();
      test_async_reset();
`ifdef SPI_ARB_TIMEOUT_EN
      test_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
